// File: rtl/periph_sdram_pkg.sv
// Shared types and sizes for the accelerator SDRAM request port.
package periph_sdram_pkg;

  localparam int unsigned ADDR_W      = 24;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BURST_LEN_W = 3;
  localparam int unsigned MAX_BEATS   = 8;
  localparam int unsigned CNT_W       = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_WR_ISSUE
  } state_e;

  function automatic logic [CNT_W-1:0] beats_from_len(input logic [BURST_LEN_W-1:0] len);
    return CNT_W'(len) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/periph_sdram_port.sv
// Responder for the peripheral SDRAM request stream; turns reads/writes into word
// transactions on the controller req/ack port. Optional watchdog: PERIPH_SDRAM_TIMEOUT_EN.
module periph_sdram_port
  import periph_sdram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   periph_rd,
  input  logic                   periph_wr,
  input  logic [ADDR_W-1:0]      periph_addr,
  input  logic [DATA_W-1:0]      periph_wdata,
  input  logic [3:0]             periph_wstrb,
  input  logic [BURST_LEN_W-1:0] periph_burst_len,
  input  logic                   periph_active,
  output logic                   periph_busy,
  output logic [DATA_W-1:0]      periph_rdata,
  output logic                   periph_rdata_valid,
  output logic                   periph_rdata_last,
  output logic                   periph_done,
  output logic                   periph_err,
  output logic                   sdram_req,
  output logic                   sdram_we,
  output logic [ADDR_W-1:0]      sdram_addr,
  output logic [DATA_W-1:0]      sdram_wdata,
  output logic [3:0]             sdram_wstrb,
  input  logic                   sdram_ack,
  input  logic [DATA_W-1:0]      sdram_rdata,
  input  logic                   sdram_rdata_valid
);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  beats_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  returned_q;
  logic [CNT_W-1:0]  issued_d;
  logic [CNT_W-1:0]  returned_d;

  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              done_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  logic ack_take;
  logic rd_ack;
  logic beat_in;
  logic to_expire;

  always_comb begin
    ack_take   = req_q & sdram_ack;
    rd_ack     = ack_take & (state_q == ST_RD_ISSUE);
    beat_in    = sdram_rdata_valid & ((state_q == ST_RD_ISSUE) | (state_q == ST_RD_DRAIN));
    issued_d   = issued_q + CNT_W'(rd_ack);
    returned_d = returned_q + CNT_W'(beat_in);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      beats_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      done_q   <= 1'b0;
      if (beat_in) begin
        rdata_q  <= sdram_rdata;
        rvalid_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          // busy is still high during the done cycle, so hold off new requests until it drops
          busy_q <= 1'b0;
          if (!done_q && periph_active && periph_rd) begin
            state_q    <= ST_RD_ISSUE;
            base_q     <= periph_addr;
            addr_q     <= periph_addr;
            beats_q    <= beats_from_len(periph_burst_len);
            issued_q   <= '0;
            returned_q <= '0;
            req_q      <= 1'b1;
            we_q       <= 1'b0;
            busy_q     <= 1'b1;
          end else if (!done_q && periph_active && periph_wr) begin
            state_q <= ST_WR_ISSUE;
            addr_q  <= periph_addr;
            wdata_q <= periph_wdata;
            wstrb_q <= periph_wstrb;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_RD_ISSUE, ST_RD_DRAIN: begin
          issued_q   <= issued_d;
          returned_q <= returned_d;
          if (beat_in && (returned_d == beats_q)) begin
            rlast_q <= 1'b1;
            done_q  <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (rd_ack) begin
            if (issued_d == beats_q) begin
              req_q   <= 1'b0;
              state_q <= ST_RD_DRAIN;
            end else begin
              addr_q <= base_q + ADDR_W'(issued_d);
            end
          end else if (to_expire) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WR_ISSUE: begin
          if (ack_take) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (to_expire) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PERIPH_SDRAM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_q;
  logic            err_q;

  assign to_expire = (state_q != ST_IDLE) && !(ack_take || sdram_rdata_valid) &&
                     (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= to_expire;
      if ((state_q == ST_IDLE) || ack_take || sdram_rdata_valid) begin
        to_q <= '0;
      end else begin
        to_q <= to_q + TO_W'(1);
      end
    end
  end

  assign periph_err = err_q;
`else
  // The watchdog limit only has meaning when the timeout logic is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_expire          = 1'b0;
  assign periph_err         = 1'b0;
`endif

  assign periph_busy        = busy_q;
  assign periph_rdata       = rdata_q;
  assign periph_rdata_valid = rvalid_q;
  assign periph_rdata_last  = rlast_q;
  assign periph_done        = done_q;
  assign sdram_req          = req_q;
  assign sdram_we           = we_q;
  assign sdram_addr         = addr_q;
  assign sdram_wdata        = wdata_q;
  assign sdram_wstrb        = wstrb_q;

endmodule

// File: tb/tb_periph_sdram_port.sv
// Scoreboard bench for periph_sdram_port with a scripted SDRAM controller responder.
module tb_periph_sdram_port;

  localparam int unsigned TO_CYC = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        periph_rd, periph_wr, periph_active;
  logic [23:0] periph_addr;
  logic [31:0] periph_wdata;
  logic [3:0]  periph_wstrb;
  logic [2:0]  periph_burst_len;
  logic        periph_busy, periph_rdata_valid, periph_rdata_last, periph_done, periph_err;
  logic [31:0] periph_rdata;
  logic        sdram_req, sdram_we, sdram_ack, sdram_rdata_valid;
  logic [23:0] sdram_addr;
  logic [31:0] sdram_wdata, sdram_rdata;
  logic [3:0]  sdram_wstrb;

  always #5 clk = ~clk;

  periph_sdram_port #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset_n(reset_n),
    .periph_rd(periph_rd), .periph_wr(periph_wr), .periph_addr(periph_addr),
    .periph_wdata(periph_wdata), .periph_wstrb(periph_wstrb),
    .periph_burst_len(periph_burst_len), .periph_active(periph_active),
    .periph_busy(periph_busy), .periph_rdata(periph_rdata),
    .periph_rdata_valid(periph_rdata_valid), .periph_rdata_last(periph_rdata_last),
    .periph_done(periph_done), .periph_err(periph_err),
    .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_wstrb(sdram_wstrb), .sdram_ack(sdram_ack),
    .sdram_rdata(sdram_rdata), .sdram_rdata_valid(sdram_rdata_valid)
  );

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        valid;
    logic        last;
    logic        done;
    logic        err;
    logic        chk_data;
  } rsp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  req_t  exp_req[$];
  rsp_t  exp_rsp[$];
  pend_t pend[$];

  int errors = 0;
  int checks = 0;

  int ack_delay  = 0;
  int data_delay = 1;
  bit ack_en     = 1'b1;
  int total_acks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Controller memory contents: one recognisable word, otherwise address-derived.
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    if (a == 24'h000100) return 32'hDEADBEEF;
    return {~a[7:0], a};
  endfunction

  // Scripted controller: ack after ack_delay cycles of req, read data data_delay cycles after ack.
  initial begin
    int    wait_cnt;
    int    cyc;
    pend_t p;
    wait_cnt = 0;
    cyc = 0;
    sdram_ack = 1'b0;
    sdram_rdata_valid = 1'b0;
    sdram_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        pend.delete();
        sdram_ack = 1'b0;
        sdram_rdata_valid = 1'b0;
        wait_cnt = 0;
      end else begin
        sdram_rdata_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          sdram_rdata = p.data;
          sdram_rdata_valid = 1'b1;
        end
        sdram_ack = 1'b0;
        if (sdram_req && ack_en) begin
          if (wait_cnt >= ack_delay) begin
            sdram_ack = 1'b1;
            wait_cnt = 0;
            total_acks++;
            if (!sdram_we) pend.push_back('{cyc + data_delay, mem_word(sdram_addr)});
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Monitor: samples mid low-phase, pops scoreboards on accepted requests and on responses.
  initial begin
    req_t        r;
    rsp_t        s;
    bit          prev_req, prev_ack, prev_svalid, prev_done, wdone_pending;
    logic [23:0] prev_addr;
    logic [31:0] prev_srdata;
    prev_req = 0; prev_ack = 0; prev_svalid = 0; prev_done = 0; wdone_pending = 0;
    prev_addr = '0; prev_srdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_req = 0; prev_ack = 0; prev_svalid = 0; prev_done = 0; wdone_pending = 0;
        continue;
      end
      if (prev_req && !prev_ack && !(periph_done && periph_err)) begin
        check("req_hold", {31'b0, sdram_req}, 32'd1);
        check("addr_hold", {8'b0, sdram_addr}, {8'b0, prev_addr});
      end
      if (wdone_pending) check("wr_done_latency", {31'b0, periph_done}, 32'd1);
      wdone_pending = sdram_req && sdram_ack && sdram_we;
      if (sdram_req && sdram_ack) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr 0x%06h we %0b, expected no request", sdram_addr, sdram_we);
        end else begin
          r = exp_req.pop_front();
          check("req_addr", {8'b0, sdram_addr}, {8'b0, r.addr});
          check("req_we", {31'b0, sdram_we}, {31'b0, r.we});
          if (r.we) begin
            check("req_wdata", sdram_wdata, r.wdata);
            check("req_wstrb", {28'b0, sdram_wstrb}, {28'b0, r.wstrb});
          end
        end
      end
      if (periph_rdata_valid) begin
        check("rd_latency", {31'b0, prev_svalid}, 32'd1);
        check("rd_pass", periph_rdata, prev_srdata);
      end
      if (periph_rdata_valid || periph_done) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got valid %0b done %0b, expected no response", periph_rdata_valid, periph_done);
        end else begin
          s = exp_rsp.pop_front();
          check("rsp_valid", {31'b0, periph_rdata_valid}, {31'b0, s.valid});
          check("rsp_last", {31'b0, periph_rdata_last}, {31'b0, s.last});
          check("rsp_done", {31'b0, periph_done}, {31'b0, s.done});
          check("rsp_err", {31'b0, periph_err}, {31'b0, s.err});
          if (s.chk_data) check("rsp_rdata", periph_rdata, s.rdata);
          check("busy_in_rsp", {31'b0, periph_busy}, 32'd1);
        end
      end
      if (prev_done) check("busy_drop", {31'b0, periph_busy}, 32'd0);
      prev_req    = sdram_req;
      prev_ack    = sdram_ack;
      prev_addr   = sdram_addr;
      prev_svalid = sdram_rdata_valid;
      prev_srdata = sdram_rdata;
      prev_done   = periph_done;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [23:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws, input logic [2:0] len);
    tick();
    periph_active = 1'b1; periph_rd = rd; periph_wr = wr;
    periph_addr = addr; periph_wdata = wd; periph_wstrb = ws; periph_burst_len = len;
    tick();
    periph_active = 1'b0; periph_rd = 1'b0; periph_wr = 1'b0;
    check("busy_cycle1", {31'b0, periph_busy}, 32'd1);
    check("req_cycle1", {31'b0, sdram_req}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((periph_busy || exp_rsp.size() != 0 || exp_req.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy=%0b rsp_left=%0d req_left=%0d after %0d cycles, expected idle",
               name, periph_busy, exp_rsp.size(), exp_req.size(), budget);
    end
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, {31'b0, periph_busy}, 32'd0);
    check({name, "_rvalid"}, {31'b0, periph_rdata_valid}, 32'd0);
    check({name, "_rlast"}, {31'b0, periph_rdata_last}, 32'd0);
    check({name, "_rdata"}, periph_rdata, 32'd0);
    check({name, "_done"}, {31'b0, periph_done}, 32'd0);
    check({name, "_err"}, {31'b0, periph_err}, 32'd0);
    check({name, "_req"}, {31'b0, sdram_req}, 32'd0);
    check({name, "_we"}, {31'b0, sdram_we}, 32'd0);
    check({name, "_addr"}, {8'b0, sdram_addr}, 32'd0);
    check({name, "_wdata"}, sdram_wdata, 32'd0);
    check({name, "_wstrb"}, {28'b0, sdram_wstrb}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks0;
    int n;
    int n_req;
    reset_n = 1'b0;
    periph_rd = 1'b0; periph_wr = 1'b0; periph_active = 1'b0;
    periph_addr = '0; periph_wdata = '0; periph_wstrb = '0; periph_burst_len = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_all_zero("reset");

    // Single read, ack 2 cycles after req, data 3 cycles after ack.
    ack_delay = 2; data_delay = 3;
    exp_req.push_back('{24'h000100, 1'b0, 32'h0, 4'h0});
    exp_rsp.push_back('{32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    issue(1'b1, 1'b0, 24'h000100, 32'h0, 4'h0, 3'd0);
    wait_done("single_read", 40);

    // Burst of 4 across the address wrap, continuous ack, data overlapping issue.
    ack_delay = 0; data_delay = 2;
    exp_req.push_back('{24'hFFFFFE, 1'b0, 32'h0, 4'h0});
    exp_req.push_back('{24'hFFFFFF, 1'b0, 32'h0, 4'h0});
    exp_req.push_back('{24'h000000, 1'b0, 32'h0, 4'h0});
    exp_req.push_back('{24'h000001, 1'b0, 32'h0, 4'h0});
    exp_rsp.push_back('{32'h01FFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_rsp.push_back('{32'h00FFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_rsp.push_back('{32'hFF000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_rsp.push_back('{32'hFE000001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    issue(1'b1, 1'b0, 24'hFFFFFE, 32'h0, 4'h0, 3'd3);
    wait_done("burst_wrap", 40);

    // Single write; burst_len must be ignored.
    ack_delay = 1; data_delay = 1;
    exp_req.push_back('{24'h001234, 1'b1, 32'h11223344, 4'b0101});
    exp_rsp.push_back('{32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    issue(1'b0, 1'b1, 24'h001234, 32'h11223344, 4'b0101, 3'd5);
    wait_done("write", 40);

    // rd and wr together: read wins; a read pulse while busy is ignored.
    exp_req.push_back('{24'h000200, 1'b0, 32'h0, 4'h0});
    exp_rsp.push_back('{32'hFF000200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    issue(1'b1, 1'b1, 24'h000200, 32'hCAFEF00D, 4'hF, 3'd0);
    tick();
    periph_active = 1'b1; periph_rd = 1'b1; periph_addr = 24'h000300;
    tick();
    periph_active = 1'b0; periph_rd = 1'b0;
    wait_done("rd_wr_collision", 40);
    repeat (5) tick();

    // Reset after 2 of 8 burst acks.
    ack_delay = 3; data_delay = 12;
    acks0 = total_acks;
    exp_req.push_back('{24'h000400, 1'b0, 32'h0, 4'h0});
    exp_req.push_back('{24'h000401, 1'b0, 32'h0, 4'h0});
    issue(1'b1, 1'b0, 24'h000400, 32'h0, 4'h0, 3'd7);
    n = 0;
    while (total_acks < acks0 + 2 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL reset_burst_acks: got %0d acks, expected 2", total_acks - acks0);
    end
    tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_reqs_seen", 32'(exp_req.size()), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    ack_delay = 1; data_delay = 2;
    exp_req.push_back('{24'h000500, 1'b0, 32'h0, 4'h0});
    exp_rsp.push_back('{32'hFF000500, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    issue(1'b1, 1'b0, 24'h000500, 32'h0, 4'h0, 3'd0);
    wait_done("post_reset_read", 40);

`ifdef PERIPH_SDRAM_TIMEOUT_EN
    // Controller never acks: watchdog ends the transaction with err.
    ack_en = 1'b0;
    exp_rsp.push_back('{32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    issue(1'b1, 1'b0, 24'h000600, 32'h0, 4'h0, 3'd0);
    n_req = 1;
    n = 0;
    while (!periph_done && n < 40) begin
      tick();
      n++;
      if (!periph_done && sdram_req) n_req++;
    end
    check("timeout_done", {31'b0, periph_done}, 32'd1);
    check("timeout_err", {31'b0, periph_err}, 32'd1);
    check("timeout_req_dropped", {31'b0, sdram_req}, 32'd0);
    check("timeout_req_cycles", 32'(n_req), TO_CYC);
    ack_en = 1'b1;
    wait_done("timeout", 20);
    exp_req.push_back('{24'h000700, 1'b0, 32'h0, 4'h0});
    exp_rsp.push_back('{32'hFF000700, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    issue(1'b1, 1'b0, 24'h000700, 32'h0, 4'h0, 3'd0);
    wait_done("after_timeout", 40);
`endif

    check("final_req_queue", 32'(exp_req.size()), 32'd0);
    check("final_rsp_queue", 32'(exp_rsp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
